// File: rtl/traffic_sequencer_pkg.sv
// Shared types and constants for the traffic-light sequencer.
package traffic_pkg;

    typedef enum logic [2:0] {MG, MY, AR1, WALK, CLR, SG, SY, AR2} phase_e;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    localparam int LAST_NORMAL_DEF = 29;
    localparam int LAST_PED_DEF    = 33;

endpackage

// File: rtl/traffic_sequencer_if.sv
// Tick/request/decoder inputs and light outputs of the traffic sequencer.
interface traffic_sequencer_if;
    logic       tick;
    logic       ped_req;
    logic       enable;
    logic [5:0] counter;
    logic       ped_mode;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;

    modport slave (
        input  tick, ped_req, enable,
        output counter, ped_mode, main_light, side_light, walk
    );

    modport master (
        output tick, ped_req, enable,
        input  counter, ped_mode, main_light, side_light, walk
    );
endinterface

// File: rtl/traffic_sequencer_ped.sv
// Pedestrian request capture; TRAFFIC_PED_SYNC_EN adds a 2-flop input synchronizer.
module ped_request_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic ped_req,
    input  logic wrap,
    output logic ped_load,
    output logic ped_pending
);
    logic ped_s;
    logic ped_pending_q, ped_pending_d;

`ifdef TRAFFIC_PED_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], ped_req};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= sync_d;
    end

    assign ped_s = sync_q[1];
`else
    assign ped_s = ped_req;
`endif

    // A request seen on the wrap tick goes straight into ped_mode, so pending is cleared, not set.
    always_comb begin
        ped_pending_d = ped_pending_q;
        if (wrap)       ped_pending_d = 1'b0;
        else if (ped_s) ped_pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ped_pending_q <= 1'b0;
        else        ped_pending_q <= ped_pending_d;
    end

    assign ped_load    = ped_pending_q | ped_s;
    assign ped_pending = ped_pending_q;
endmodule

// File: rtl/traffic_sequencer.sv
// Second counter and light phase machine; pedestrian sync selected by TRAFFIC_PED_SYNC_EN.
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int LAST_NORMAL = LAST_NORMAL_DEF,
    parameter int LAST_PED    = LAST_PED_DEF
) (
    input logic               clk,
    input logic               rst_n,
    traffic_sequencer_if.slave bus
);
    logic [5:0] counter_q, counter_d;
    logic       ped_mode_q, ped_mode_d;
    logic       step_q, step_d;
    phase_e     phase_q, phase_d;
    logic [2:0] main_q, main_d;
    logic [2:0] side_q, side_d;
    logic       walk_q, walk_d;
    logic [5:0] last_cnt;
    logic       wrap;
    logic       ped_load;
    logic       ped_pending;

    assign last_cnt = ped_mode_q ? 6'(LAST_PED) : 6'(LAST_NORMAL);
    assign wrap     = bus.tick && (counter_q == last_cnt);

    ped_request_latch u_ped (
        .clk        (clk),
        .rst_n      (rst_n),
        .ped_req    (bus.ped_req),
        .wrap       (wrap),
        .ped_load   (ped_load),
        .ped_pending(ped_pending)
    );

    always_comb begin
        counter_d  = counter_q;
        ped_mode_d = ped_mode_q;
        step_d     = bus.tick;
        if (bus.tick) begin
            if (wrap) begin
                counter_d  = 6'd0;
                ped_mode_d = ped_load;
            end else begin
                counter_d = counter_q + 6'd1;
            end
        end
    end

    // SY is left at the wrap in a pedestrian cycle; the new cycle's mode may already be normal.
    always_comb begin
        phase_d = phase_q;
        if (step_q && bus.enable) begin
            case (phase_q)
                MG:      phase_d = MY;
                MY:      phase_d = AR1;
                AR1:     phase_d = ped_mode_q ? WALK : SG;
                WALK:    phase_d = CLR;
                CLR:     phase_d = SG;
                SG:      phase_d = SY;
                SY:      phase_d = (ped_mode_q || counter_q == 6'd0) ? MG : AR2;
                AR2:     phase_d = MG;
                default: phase_d = AR2;
            endcase
        end

        main_d = LIGHT_RED;
        side_d = LIGHT_RED;
        walk_d = 1'b0;
        case (phase_d)
            MG:      main_d = LIGHT_GRN;
            MY:      main_d = LIGHT_YEL;
            WALK:    walk_d = 1'b1;
            SG:      side_d = LIGHT_GRN;
            SY:      side_d = LIGHT_YEL;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q  <= 6'd0;
            ped_mode_q <= 1'b0;
            step_q     <= 1'b1;
            phase_q    <= AR2;
            main_q     <= LIGHT_RED;
            side_q     <= LIGHT_RED;
            walk_q     <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            ped_mode_q <= ped_mode_d;
            step_q     <= step_d;
            phase_q    <= phase_d;
            main_q     <= main_d;
            side_q     <= side_d;
            walk_q     <= walk_d;
        end
    end

    assign bus.counter    = counter_q;
    assign bus.ped_mode   = ped_mode_q;
    assign bus.main_light = main_q;
    assign bus.side_light = side_q;
    assign bus.walk       = walk_q;
endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for traffic_sequencer with an attached enable-decoder model.
module tb_traffic_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cnt_m  = 0;
    bit   ped_m  = 1'b0;
    bit   ped_next = 1'b0;

`ifdef TRAFFIC_PED_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam logic [13:0] RST_VEC = {6'd0, 1'b0, 3'b100, 3'b100, 1'b0};

    traffic_sequencer_if bus ();

    traffic_sequencer dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic dec(logic [5:0] c, logic p);
        if (!p) return (c == 0) || (c == 15) || (c == 17) || (c == 19) || (c == 27) || (c == 29);
        return (c == 0) || (c == 11) || (c == 13) || (c == 15) || (c == 21) || (c == 23) || (c == 33);
    endfunction

    assign bus.enable = dec(bus.counter, bus.ped_mode);

    // {counter, ped_mode, main, side, walk} from the published phase tables
    function automatic logic [13:0] exp_vec(int c, bit p);
        logic [2:0] m, s;
        logic       w;
        logic [5:0] c6;
        m = 3'b100; s = 3'b100; w = 1'b0; c6 = c[5:0];
        if (!p) begin
            if (c <= 14)                m = 3'b001;
            else if (c <= 16)           m = 3'b010;
            else if (c >= 19 && c <= 26) s = 3'b001;
            else if (c >= 27 && c <= 28) s = 3'b010;
        end else begin
            if (c <= 10)                m = 3'b001;
            else if (c <= 12)           m = 3'b010;
            else if (c >= 15 && c <= 20) w = 1'b1;
            else if (c >= 23 && c <= 32) s = 3'b001;
            else if (c == 33)           s = 3'b010;
        end
        return {c6, p, m, s, w};
    endfunction

    logic [13:0] obs;
    assign obs = {bus.counter, bus.ped_mode, bus.main_light, bus.side_light, bus.walk};

    task automatic do_tick(input bit req);
        @(negedge clk);
        bus.tick = 1'b1;
        if (req) bus.ped_req = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        if (req) bus.ped_req = 1'b0;
        @(posedge clk);
        #1;
        if (cnt_m == (ped_m ? 33 : 29)) begin
            cnt_m = 0;
            ped_m = ped_next;
        end else begin
            cnt_m++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.tick = 1'b0;
        bus.ped_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== RST_VEC) begin
            errors++; $display("FAIL reset_state: got %b exp %b", obs, RST_VEC);
        end
        checks++;
        if (dut.u_ped.ped_pending !== 1'b0) begin
            errors++; $display("FAIL reset_pending: got %b exp 0", dut.u_ped.ped_pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cnt_m = 0; ped_m = 1'b0;
        checks++;
        if (obs !== exp_vec(0, 1'b0)) begin
            errors++; $display("FAIL reset_release_mg: got %b exp %b", obs, exp_vec(0, 1'b0));
        end
    endtask

    task automatic test_normal_cycle();
        ped_next = 1'b0;
        for (int i = 0; i < 30; i++) begin
            do_tick(1'b0);
            checks++;
            if (obs !== exp_vec(cnt_m, ped_m)) begin
                errors++; $display("FAIL normal_cycle: got %b exp %b", obs, exp_vec(cnt_m, ped_m));
            end
        end
    endtask

    task automatic test_ped_press();
        ped_next = 1'b0;
        for (int i = 0; i < 30; i++) begin
            do_tick(1'b0);
            checks++;
            if (obs !== exp_vec(cnt_m, ped_m)) begin
                errors++; $display("FAIL press_normal: got %b exp %b", obs, exp_vec(cnt_m, ped_m));
            end
            if (cnt_m == 5 && !ped_next) begin
                @(negedge clk);
                bus.ped_req = 1'b1;
                repeat (3) @(negedge clk);
                bus.ped_req = 1'b0;
                ped_next = 1'b1;
                checks++;
                if (dut.u_ped.ped_pending !== 1'b1) begin
                    errors++; $display("FAIL press_pending: got %b exp 1", dut.u_ped.ped_pending);
                end
            end
        end
        ped_next = 1'b0;
        for (int i = 0; i < 34; i++) begin
            do_tick(1'b0);
            checks++;
            if (obs !== exp_vec(cnt_m, ped_m)) begin
                errors++; $display("FAIL ped_cycle: got %b exp %b", obs, exp_vec(cnt_m, ped_m));
            end
        end
    endtask

    task automatic test_ped_to_normal();
        ped_next = 1'b0;
        for (int i = 0; i < 30; i++) begin
            do_tick(1'b0);
            checks++;
            if (obs !== exp_vec(cnt_m, ped_m)) begin
                errors++; $display("FAIL ped_to_normal: got %b exp %b", obs, exp_vec(cnt_m, ped_m));
            end
        end
    endtask

    task automatic test_wrap_edge();
        ped_next = 1'b0;
        for (int i = 0; i < 29; i++) begin
            do_tick(1'b0);
            checks++;
            if (obs !== exp_vec(cnt_m, ped_m)) begin
                errors++; $display("FAIL wrap_pre: got %b exp %b", obs, exp_vec(cnt_m, ped_m));
            end
        end
        ped_next = 1'b1;
`ifdef TRAFFIC_PED_SYNC_EN
        @(negedge clk);
        bus.ped_req = 1'b1;
        @(negedge clk);
        bus.ped_req = 1'b0;
        do_tick(1'b0);
`else
        do_tick(1'b1);
`endif
        checks++;
        if (obs !== exp_vec(0, 1'b1)) begin
            errors++; $display("FAIL wrap_edge_mode: got %b exp %b", obs, exp_vec(0, 1'b1));
        end
        checks++;
        if (dut.u_ped.ped_pending !== 1'b0) begin
            errors++; $display("FAIL wrap_edge_pending: got %b exp 0", dut.u_ped.ped_pending);
        end
        ped_next = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_tick(1'b0);
            checks++;
            if (obs !== exp_vec(cnt_m, ped_m)) begin
                errors++; $display("FAIL wrap_post: got %b exp %b", obs, exp_vec(cnt_m, ped_m));
            end
        end
        checks++;
        if (dut.u_ped.ped_pending !== 1'b0) begin
            errors++; $display("FAIL wrap_post_pending: got %b exp 0", dut.u_ped.ped_pending);
        end
    endtask

    task automatic test_sync_latency();
        @(negedge clk);
        bus.ped_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (dut.u_ped.ped_pending !== (k >= LAT)) begin
                errors++;
                $display("FAIL sync_latency clk%0d: got %b exp %b", k, dut.u_ped.ped_pending, (k >= LAT));
            end
        end
        @(negedge clk);
        bus.ped_req = 1'b0;
        ped_next = 1'b1;
        for (int i = 0; i < 40; i++) begin
            do_tick(1'b0);
            checks++;
            if (obs !== exp_vec(cnt_m, ped_m)) begin
                errors++; $display("FAIL latency_cycle: got %b exp %b", obs, exp_vec(cnt_m, ped_m));
            end
            if (cnt_m == 0) break;
        end
        checks++;
        if (dut.u_ped.ped_pending !== 1'b0) begin
            errors++; $display("FAIL pending_cleared: got %b exp 0", dut.u_ped.ped_pending);
        end
    endtask

    task automatic test_reset_mid();
        ped_next = 1'b0;
        for (int i = 0; i < 20; i++) begin
            do_tick(1'b0);
            checks++;
            if (obs !== exp_vec(cnt_m, ped_m)) begin
                errors++; $display("FAIL mid_pre: got %b exp %b", obs, exp_vec(cnt_m, ped_m));
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== RST_VEC) begin
            errors++; $display("FAIL mid_reset_async: got %b exp %b", obs, RST_VEC);
        end
        @(negedge clk);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        checks++;
        if (obs !== RST_VEC) begin
            errors++; $display("FAIL tick_in_reset: got %b exp %b", obs, RST_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cnt_m = 0; ped_m = 1'b0;
        checks++;
        if (obs !== exp_vec(0, 1'b0)) begin
            errors++; $display("FAIL mid_release_mg: got %b exp %b", obs, exp_vec(0, 1'b0));
        end
        for (int i = 0; i < 5; i++) begin
            do_tick(1'b0);
            checks++;
            if (obs !== exp_vec(cnt_m, ped_m)) begin
                errors++; $display("FAIL mid_post: got %b exp %b", obs, exp_vec(cnt_m, ped_m));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal_cycle();
        test_ped_press();
        test_ped_to_normal();
        test_wrap_edge();
        test_sync_latency();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
